// File: rtl/pow_target_compare_seq.sv
// pow_target_compare_seq
//
// Decides whether a candidate hash meets a proof-of-work target (hash <= target).
// Both words are captured on an accepted start. They are then scanned
// bit-serially, MSB first, through a single 1-bit equal/greater/less stage.
// The result is returned as registered flags with a one-cycle done pulse.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   request a compare (accepted only in IDLE, ignored otherwise)
//   abort   in   synchronous cancel of a running scan (no done pulse)
//   hash    in   [WIDTH-1:0] candidate hash, captured on accepted start
//   target  in   [WIDTH-1:0] difficulty target, captured on accepted start
//   busy    out  high while scanning
//   done    out  one-cycle pulse when the flags below become valid
//   eq      out  hash == target
//   gt      out  hash >  target
//   lt      out  hash <  target
//   meets   out  hash <= target
//
// Parameters:
//   WIDTH       word width, 2..256
//   EARLY_EXIT  1: finish on the first differing bit; 0: always scan WIDTH bits
module pow_target_compare_seq #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] hash,
  input  logic [WIDTH-1:0] target,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             meets
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sticky ordering decision, set by the most significant differing bit.
  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_GT   = 2'd1,
    DEC_LT   = 2'd2
  } dec_t;

  // Single-bit compare stage.
  function automatic dec_t cmp_bit(input logic h_bit, input logic t_bit);
    dec_t r;
    if (h_bit == t_bit) r = DEC_NONE;
    else if (h_bit)     r = DEC_GT;
    else                r = DEC_LT;
    return r;
  endfunction

  state_t             state_q, state_d;
  dec_t               dec_q, dec_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               meets_q, meets_d;

  dec_t               bit_dec;
  dec_t               dec_now;

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    h_d     = h_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    meets_d = meets_q;
    bit_dec = cmp_bit(h_q[WIDTH-1], t_q[WIDTH-1]);
    // Once a difference has been seen, later bits cannot change the decision.
    dec_now = (dec_q == DEC_NONE) ? bit_dec : dec_q;

    case (state_q)
      ST_IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          h_d     = hash;
          t_d     = target;
          cnt_d   = CNT_W'(WIDTH - 1);
          dec_d   = DEC_NONE;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          meets_d = 1'b0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (abort) begin
          // Flags were cleared on accept and remain 0.
          state_d = ST_IDLE;
        end else begin
          h_d   = {h_q[WIDTH-2:0], 1'b0};
          t_d   = {t_q[WIDTH-2:0], 1'b0};
          dec_d = dec_now;
          // The counter stops at 0 rather than wrapping.
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (((EARLY_EXIT != 0) && (dec_now != DEC_NONE)) || (cnt_q == '0)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            eq_d    = (dec_now == DEC_NONE);
            gt_d    = (dec_now == DEC_GT);
            lt_d    = (dec_now == DEC_LT);
            meets_d = (dec_now != DEC_GT);
          end
        end
      end

      ST_DONE: begin
        // start is ignored here; abort has nothing left to cancel.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dec_q   <= DEC_NONE;
      h_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      meets_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      h_q     <= h_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      meets_q <= meets_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign eq    = eq_q;
  assign gt    = gt_q;
  assign lt    = lt_q;
  assign meets = meets_q;

endmodule

// File: tb/tb_pow_target_compare_seq.sv
// Bench for pow_target_compare_seq: two WIDTH=8 instances, one with early exit
// (dut_a) and one with fixed latency (dut_b). Stimulus pushes the expected
// flags/latency into a per-instance queue; monitors pop on each done pulse.
module tb_pow_target_compare_seq;

  logic       clk;
  logic       rst;
  logic       start_a, abort_a, start_b, abort_b;
  logic [7:0] hash_a, target_a, hash_b, target_b;
  logic       busy_a, done_a, eq_a, gt_a, lt_a, meets_a;
  logic       busy_b, done_b, eq_b, gt_b, lt_b, meets_b;

  typedef struct {
    logic [3:0] f;    // {eq, gt, lt, meets}
    int         lat;  // edges from accept to done, -1 = not checked
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  pow_target_compare_seq #(.WIDTH(8), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .hash(hash_a), .target(target_a), .busy(busy_a), .done(done_a),
    .eq(eq_a), .gt(gt_a), .lt(lt_a), .meets(meets_a)
  );

  pow_target_compare_seq #(.WIDTH(8), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .hash(hash_b), .target(target_b), .busy(busy_b), .done(done_b),
    .eq(eq_b), .gt(gt_b), .lt(lt_b), .meets(meets_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for dut_a
  initial begin
    logic prev_busy, prev_done;
    int   acc;
    exp_t e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    acc = 0;
    forever begin
      @(negedge clk);
      if (busy_a && !prev_busy) begin
        acc = edge_cnt;
        chk("gap_a", {31'd0, prev_done}, 32'd0);
      end
      if (done_a) begin
        chk("pulse_a", {31'd0, prev_done}, 32'd0);
        if (exp_a.size() == 0) begin
          chk("unexpected_done_a", 32'd1, 32'd0);
        end else begin
          e = exp_a.pop_front();
          chk("flags_a", {28'd0, eq_a, gt_a, lt_a, meets_a}, {28'd0, e.f});
          if (e.lat >= 0) chk("latency_a", edge_cnt - acc, e.lat);
        end
      end
      prev_busy = busy_a;
      prev_done = done_a;
    end
  end

  // Monitor for dut_b
  initial begin
    logic prev_busy, prev_done;
    int   acc;
    exp_t e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    acc = 0;
    forever begin
      @(negedge clk);
      if (busy_b && !prev_busy) begin
        acc = edge_cnt;
        chk("gap_b", {31'd0, prev_done}, 32'd0);
      end
      if (done_b) begin
        chk("pulse_b", {31'd0, prev_done}, 32'd0);
        if (exp_b.size() == 0) begin
          chk("unexpected_done_b", 32'd1, 32'd0);
        end else begin
          e = exp_b.pop_front();
          chk("flags_b", {28'd0, eq_b, gt_b, lt_b, meets_b}, {28'd0, e.f});
          if (e.lat >= 0) chk("latency_b", edge_cnt - acc, e.lat);
        end
      end
      prev_busy = busy_b;
      prev_done = done_b;
    end
  end

  task automatic push_exp(input int which, input logic [3:0] f, input int lat);
    exp_t e;
    e.f   = f;
    e.lat = lat;
    if (which == 0) exp_a.push_back(e);
    else            exp_b.push_back(e);
  endtask

  task automatic wait_done(input int which);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((which == 0) ? done_a : done_b) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(which == 0 ? "timeout_done_a" : "timeout_done_b", 32'd0, 32'd1);
  endtask

  task automatic wait_busy(input int which);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((which == 0) ? busy_a : busy_b) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(which == 0 ? "timeout_busy_a" : "timeout_busy_b", 32'd0, 32'd1);
  endtask

  // Issue one compare from a negedge; returns in the first IDLE cycle after done.
  task automatic run(input int which, input logic [7:0] h, input logic [7:0] t,
                     input logic [3:0] f, input int lat);
    push_exp(which, f, lat);
    if (which == 0) begin
      hash_a = h; target_a = t; start_a = 1'b1;
    end else begin
      hash_b = h; target_b = t; start_b = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done(which);
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; hash_a = 8'h00; target_a = 8'h00;
    start_b = 1'b0; abort_b = 1'b0; hash_b = 8'h00; target_b = 8'h00;

    // Reset state
    @(negedge clk);
    chk("reset_a", {26'd0, busy_a, done_a, eq_a, gt_a, lt_a, meets_a}, 32'd0);
    chk("reset_b", {26'd0, busy_b, done_b, eq_b, gt_b, lt_b, meets_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Early exit: equal words, full WIDTH latency, flags hold afterwards
    run(0, 8'h3C, 8'h3C, 4'b1001, 8);
    repeat (20) @(negedge clk);
    chk("hold_a", {27'd0, busy_a, eq_a, gt_a, lt_a, meets_a}, {27'd0, 5'b01001});

    // Early exit: MSB differs, then bit 1 differs
    run(0, 8'h80, 8'h7F, 4'b0100, 1);
    run(0, 8'h10, 8'h12, 4'b0011, 7);

    // Fixed latency: later bits must not overturn the first difference
    run(1, 8'h80, 8'h7F, 4'b0100, 8);
    run(1, 8'h10, 8'h12, 4'b0011, 8);
    run(1, 8'h5A, 8'h5A, 4'b1001, 8);
    chk("hold_b", {28'd0, eq_b, gt_b, lt_b, meets_b}, {28'd0, 4'b1001});

    // start held high; hash disturbed during the second scan
    hash_a = 8'h01; target_a = 8'h02;
    push_exp(0, 4'b0011, 7);
    push_exp(0, 4'b0011, 7);
    push_exp(0, 4'b0011, 7);
    start_a = 1'b1;
    wait_done(0);
    wait_busy(0);
    @(negedge clk);
    hash_a = 8'hFF;
    wait_done(0);
    hash_a = 8'h01;
    wait_done(0);
    start_a = 1'b0;
    repeat (3) @(negedge clk);

    // Abort on the third SCAN cycle
    hash_a = 8'h00; target_a = 8'h01; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_a", {26'd0, busy_a, done_a, eq_a, gt_a, lt_a, meets_a}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    chk("abort_no_done_a", dcount, 32'd0);

    // abort wins over start in IDLE
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    chk("abort_start_busy_a", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    chk("abort_start_idle_a", {31'd0, busy_a}, 32'd0);

    // Asynchronous reset mid-scan on dut_a; dut_b idle holding eq flags
    hash_a = 8'h00; target_a = 8'h01; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy_a", {31'd0, busy_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_a", {26'd0, busy_a, done_a, eq_a, gt_a, lt_a, meets_a}, 32'd0);
    chk("async_reset_b", {26'd0, busy_b, done_b, eq_b, gt_b, lt_b, meets_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle_a", {31'd0, busy_a}, 32'd0);

    // Normal compare after reset
    run(0, 8'hFF, 8'hFF, 4'b1001, 8);
    run(1, 8'hFF, 8'hFF, 4'b1001, 8);
    repeat (4) @(negedge clk);

    chk("queue_empty_a", exp_a.size(), 32'd0);
    chk("queue_empty_b", exp_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
